// File: rtl/alu_issue_scheduler.sv
// Purpose: round-robin issue of one ready reservation-station entry at a time to the single ALU,
//          then holding the tagged result on the CDB until the consumer takes it.
// Latency: 5 cycles minimum per operation (IDLE edge, ISSUE, WAIT x2, BCAST with immediate ack).
// Backpressure: cdb_ack low keeps the result on the CDB and blocks further issue; req is sampled only in IDLE.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req/req_opcode/op1/op2/tag   per-requester ready flag and packed instruction fields
//   grant                        one-hot, one-cycle acceptance pulse (ISSUE cycle)
//   alu_start/alu_*              start pulse and registered operands to the ALU
//   alu_done/alu_tag/alu_result  ALU completion
//   cdb_valid/tag/data, cdb_ack  result broadcast with consumer acknowledge
//   busy, err                    not-IDLE indicator, sticky timeout flag
module alu_issue_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [6*N_REQ-1:0]   req_opcode,
  input  logic [32*N_REQ-1:0]  req_op1,
  input  logic [32*N_REQ-1:0]  req_op2,
  input  logic [5*N_REQ-1:0]   req_tag,
  output logic [N_REQ-1:0]     grant,
  output logic                 alu_start,
  output logic [5:0]           alu_opcode,
  output logic [31:0]          alu_op1,
  output logic [31:0]          alu_op2,
  output logic [4:0]           alu_dest_tag,
  input  logic                 alu_done,
  input  logic [4:0]           alu_tag,
  input  logic [31:0]          alu_result,
  output logic                 cdb_valid,
  output logic [4:0]           cdb_tag,
  output logic [31:0]          cdb_data,
  input  logic                 cdb_ack,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BCAST} state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   win_idx;
  logic [N_REQ-1:0] win_onehot;
  logic [CW-1:0]   wait_cnt;
  int              win_sel;

  // (base + off) mod N_REQ for off in 0..N_REQ-1
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IW-1:0];
  endfunction

  // Scan from the highest rotation offset down so the lowest offset that hits
  // (the first requester at or after rr_ptr) is the one left in win_idx.
  always_comb begin
    win_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_ptr, k)]) win_idx = wrap_add(rr_ptr, k);
    end
    win_sel = int'(win_idx);
    win_onehot = '0;
    win_onehot[win_idx] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      wait_cnt     <= '0;
      grant        <= '0;
      alu_start    <= 1'b0;
      alu_opcode   <= '0;
      alu_op1      <= '0;
      alu_op2      <= '0;
      alu_dest_tag <= '0;
      cdb_valid    <= 1'b0;
      cdb_tag      <= '0;
      cdb_data     <= '0;
      err          <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            alu_opcode   <= req_opcode[win_sel*6 +: 6];
            alu_op1      <= req_op1[win_sel*32 +: 32];
            alu_op2      <= req_op2[win_sel*32 +: 32];
            alu_dest_tag <= req_tag[win_sel*5 +: 5];
            grant        <= win_onehot;
            alu_start    <= 1'b1;
            rr_ptr       <= wrap_add(win_idx, 1);
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          grant     <= '0;
          alu_start <= 1'b0;
          wait_cnt  <= '0;
          state     <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            cdb_tag   <= alu_tag;
            cdb_data  <= alu_result;
            cdb_valid <= 1'b1;
            state     <= S_BCAST;
          end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            // ALU never answered: broadcast a poison value on the original
            // destination tag so the waiting consumer is released.
            err       <= 1'b1;
            cdb_tag   <= alu_dest_tag;
            cdb_data  <= 32'hDEADBEEF;
            cdb_valid <= 1'b1;
            state     <= S_BCAST;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_BCAST: begin
          if (cdb_ack) begin
            cdb_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Purpose: directed bench for alu_issue_scheduler with a behavioural 2-cycle ALU and a CDB scoreboard.
// Latency: not applicable (testbench).
// Backpressure: cdb_ack is driven by the directed sequence; held low where the result must be stalled.
module tb_alu_issue_scheduler;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [6*N-1:0]  req_opcode;
  logic [32*N-1:0] req_op1;
  logic [32*N-1:0] req_op2;
  logic [5*N-1:0]  req_tag;
  logic [N-1:0]  grant;
  logic          alu_start;
  logic [5:0]    alu_opcode;
  logic [31:0]   alu_op1;
  logic [31:0]   alu_op2;
  logic [4:0]    alu_dest_tag;
  logic          alu_done;
  logic [4:0]    alu_tag;
  logic [31:0]   alu_result;
  logic          cdb_valid;
  logic [4:0]    cdb_tag;
  logic [31:0]   cdb_data;
  logic          cdb_ack;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic suppress_done = 1'b0;
  logic [36:0] sb[$];

  alu_issue_scheduler #(.N_REQ(N), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req(req), .req_opcode(req_opcode), .req_op1(req_op1),
    .req_op2(req_op2), .req_tag(req_tag), .grant(grant), .alu_start(alu_start),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_dest_tag(alu_dest_tag), .alu_done(alu_done), .alu_tag(alu_tag),
    .alu_result(alu_result), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_ack(cdb_ack), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU: done two cycles after the start edge.
  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      6'd0: return a + b;
      6'd1: return a - b;
      6'd2: return a & b;
      6'd3: return a | b;
      6'd4: return a ^ b;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  logic st_d1, st_d2;
  logic [5:0]  m_opc;
  logic [31:0] m_a, m_b;
  logic [4:0]  m_tag;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st_d1 <= 1'b0; st_d2 <= 1'b0;
      m_opc <= '0; m_a <= '0; m_b <= '0; m_tag <= '0;
    end else begin
      st_d1 <= alu_start;
      st_d2 <= st_d1;
      if (alu_start) begin
        m_opc <= alu_opcode; m_a <= alu_op1; m_b <= alu_op2; m_tag <= alu_dest_tag;
      end
    end
  end
  assign alu_done   = st_d2 & ~suppress_done;
  assign alu_tag    = m_tag;
  assign alu_result = alu_f(m_opc, m_a, m_b);

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // CDB scoreboard: compare on every accepted broadcast.
  always @(negedge clk) begin
    if (!rst && cdb_valid && cdb_ack) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL cdb_unexpected: observed tag %0h data %0h expected no broadcast", cdb_tag, cdb_data);
      end
      if (sb.size() != 0) begin
        logic [36:0] e;
        e = sb.pop_front();
        chk("cdb_tag", {27'd0, cdb_tag}, {27'd0, e[36:32]});
        chk("cdb_data", cdb_data, e[31:0]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [5:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
    req_opcode[i*6 +: 6] = opc;
    req_op1[i*32 +: 32]  = a;
    req_op2[i*32 +: 32]  = b;
    req_tag[i*5 +: 5]    = tag;
  endtask

  task automatic wait_grant(input string name, input logic [N-1:0] exp, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == '0 && n < 12);
    chk(name, {28'd0, grant}, {28'd0, exp});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy && n < 30);
    chk(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t_prev;
    logic [N-1:0] rr_exp[5];

    rst = 1'b1; req = '0; cdb_ack = 1'b0;
    req_opcode = '0; req_op1 = '0; req_op2 = '0; req_tag = '0;
    #1;
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_alu_start", {31'd0, alu_start}, 32'd0);
    chk("rst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    tick(); tick();
    rst = 1'b0;

    // Round-robin with all four requesters held and immediate ack.
    set_req(0, 6'd0, 32'd1, 32'd2, 5'd10);
    set_req(1, 6'd1, 32'd20, 32'd5, 5'd11);
    set_req(2, 6'd2, 32'hFF0F, 32'h0FF0, 5'd12);
    set_req(3, 6'd4, 32'hAAAA, 32'h5555, 5'd13);
    sb.push_back({5'd10, 32'd3});
    sb.push_back({5'd11, 32'd15});
    sb.push_back({5'd12, 32'h0F00});
    sb.push_back({5'd13, 32'hFFFF});
    sb.push_back({5'd10, 32'd3});
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    cdb_ack = 1'b1;
    req = 4'b1111;
    t_prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_grant($sformatf("rr_grant%0d", g), rr_exp[g], n);
      if (g > 0) chk($sformatf("rr_spacing%0d", g), cyc - t_prev, 32'd5);
      t_prev = cyc;
    end
    req = '0;
    wait_idle("rr_drain");

    // Single request with exact latency.
    cdb_ack = 1'b0;
    set_req(1, 6'd0, 32'd5, 32'd7, 5'd3);
    sb.push_back({5'd3, 32'd12});
    req = 4'b0010;
    wait_grant("single_grant", 4'b0010, n);
    chk("single_start", {31'd0, alu_start}, 32'd1);
    chk("single_opcode", {26'd0, alu_opcode}, 32'd0);
    chk("single_op1", alu_op1, 32'd5);
    chk("single_op2", alu_op2, 32'd7);
    chk("single_dtag", {27'd0, alu_dest_tag}, 32'd3);
    req = '0;
    tick();
    chk("single_start_pulse", {31'd0, alu_start}, 32'd0);
    chk("single_grant_pulse", {28'd0, grant}, 32'd0);
    chk("single_op1_hold", alu_op1, 32'd5);
    tick();
    chk("single_no_early_cdb", {31'd0, cdb_valid}, 32'd0);
    tick();
    chk("single_cdb_valid", {31'd0, cdb_valid}, 32'd1);
    chk("single_cdb_tag", {27'd0, cdb_tag}, 32'd3);
    chk("single_cdb_data", cdb_data, 32'd12);
    tick();
    chk("single_cdb_hold", {31'd0, cdb_valid}, 32'd1);
    cdb_ack = 1'b1;
    tick();
    chk("single_cdb_drop", {31'd0, cdb_valid}, 32'd0);
    chk("single_busy_clear", {31'd0, busy}, 32'd0);

    // Unknown opcode: ALU returns poison, scheduler err stays clear.
    set_req(0, 6'h3F, 32'd1, 32'd2, 5'd1);
    sb.push_back({5'd1, 32'hDEADBEEF});
    req = 4'b0001;
    wait_grant("unk_grant", 4'b0001, n);
    req = '0;
    wait_idle("unk_drain");
    chk("unk_err", {31'd0, err}, 32'd0);

    // Backpressure: result held for 6 cycles while another request waits.
    cdb_ack = 1'b0;
    set_req(0, 6'd1, 32'd10, 32'd3, 5'd4);
    sb.push_back({5'd4, 32'd7});
    req = 4'b0001;
    wait_grant("bp_grant", 4'b0001, n);
    set_req(2, 6'd0, 32'd100, 32'd1, 5'd6);
    sb.push_back({5'd6, 32'd101});
    req = 4'b0100;
    n = 0;
    do begin tick(); n++; end while (!cdb_valid && n < 12);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("bp_valid%0d", c), {31'd0, cdb_valid}, 32'd1);
      chk($sformatf("bp_data%0d", c), cdb_data, 32'd7);
      chk($sformatf("bp_tag%0d", c), {27'd0, cdb_tag}, 32'd4);
      chk($sformatf("bp_nogrant%0d", c), {28'd0, grant}, 32'd0);
      if (c < 5) tick();
    end
    cdb_ack = 1'b1;
    tick();
    chk("bp_idle_nogrant", {28'd0, grant}, 32'd0);
    chk("bp_idle_valid", {31'd0, cdb_valid}, 32'd0);
    wait_grant("bp_next_grant", 4'b0100, n);
    chk("bp_next_delay", n, 32'd1);
    req = '0;
    wait_idle("bp_drain");

    // Timeout: ALU never signals done.
    cdb_ack = 1'b0;
    suppress_done = 1'b1;
    set_req(3, 6'd0, 32'd1, 32'd1, 5'd9);
    sb.push_back({5'd9, 32'hDEADBEEF});
    req = 4'b1000;
    wait_grant("to_grant", 4'b1000, n);
    req = '0;
    for (int c = 0; c < 8; c++) tick();
    chk("to_not_yet_valid", {31'd0, cdb_valid}, 32'd0);
    chk("to_not_yet_err", {31'd0, err}, 32'd0);
    tick();
    chk("to_valid", {31'd0, cdb_valid}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_tag", {27'd0, cdb_tag}, 32'd9);
    chk("to_data", cdb_data, 32'hDEADBEEF);
    cdb_ack = 1'b1;
    tick();
    suppress_done = 1'b0;

    // Successful operation after timeout: err remains set.
    set_req(2, 6'd3, 32'hF0, 32'h0F, 5'd2);
    sb.push_back({5'd2, 32'hFF});
    req = 4'b0100;
    wait_grant("post_to_grant", 4'b0100, n);
    req = '0;
    wait_idle("post_to_drain");
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset during WAIT: everything clears asynchronously, nothing is broadcast.
    cdb_ack = 1'b0;
    set_req(1, 6'd0, 32'd8, 32'd8, 5'd5);
    req = 4'b0010;
    wait_grant("mid_grant", 4'b0010, n);
    req = '0;
    tick();
    rst = 1'b1;
    #1;
    chk("arst_grant", {28'd0, grant}, 32'd0);
    chk("arst_alu_start", {31'd0, alu_start}, 32'd0);
    chk("arst_opcode", {26'd0, alu_opcode}, 32'd0);
    chk("arst_op1", alu_op1, 32'd0);
    chk("arst_op2", alu_op2, 32'd0);
    chk("arst_dtag", {27'd0, alu_dest_tag}, 32'd0);
    chk("arst_cdb_valid", {31'd0, cdb_valid}, 32'd0);
    chk("arst_cdb_tag", {27'd0, cdb_tag}, 32'd0);
    chk("arst_cdb_data", cdb_data, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_err", {31'd0, err}, 32'd0);
    tick();
    rst = 1'b0;

    // rr_ptr was 2 before reset; after reset the scan starts at 0, so 1 beats 3.
    cdb_ack = 1'b1;
    set_req(1, 6'd0, 32'd2, 32'd3, 5'd7);
    set_req(3, 6'd0, 32'd4, 32'd4, 5'd8);
    sb.push_back({5'd7, 32'd5});
    req = 4'b1010;
    wait_grant("post_rst_grant", 4'b0010, n);
    req = 4'b1000;
    sb.push_back({5'd8, 32'd8});
    wait_grant("post_rst_grant3", 4'b1000, n);
    req = '0;
    wait_idle("post_rst_drain");

    chk("sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
